// File: rtl/bus_rx_pkg.sv
// bus_rx_pkg: shared types and constants for the my_bus slave receiver
package bus_rx_pkg;
   typedef enum logic [0:0] {RX_IDLE, RX_GRANT} rx_state_e;
   localparam int DEFAULT_DATA_W = 8;
   localparam int STAT_W = 16;
endpackage

// File: rtl/bus_rx_fifo.sv
// bus_rx_fifo: power-of-two byte FIFO with zero-latency head and occupancy count
module bus_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   pop,
   output logic [DATA_W-1:0]      head_data,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [LW-1:0]     level_q;
   logic              do_push, do_pop;
   assign do_push   = push && (level_q != LW'(DEPTH));
   assign do_pop    = pop && (level_q != '0);
   assign level     = level_q;
   assign head_data = (level_q != '0) ? mem_q[rd_q] : '0;
   // storage array; contents are don't-care until counted by level
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data;
   end
   // pointers wrap naturally at the power-of-two depth; level tracks push minus pop
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         level_q <= level_q + LW'(do_push) - LW'(do_pop);
      end
   end
endmodule

// File: rtl/bus_slave_rx.sv
// bus_slave_rx: my_bus req/gnt slave receiver feeding a FIFO-backed valid/ready stream; BUS_SLAVE_RX_STATS_EN adds transfer/stall counters
module bus_slave_rx
   import bus_rx_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic [DATA_W-1:0]      data,
   input  logic                   enable,
   output logic                   gnt,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level
`ifdef BUS_SLAVE_RX_STATS_EN
   ,
   output logic [STAT_W-1:0]      xfer_count,
   output logic [STAT_W-1:0]      stall_count
`endif
);
   localparam int LW = $clog2(DEPTH) + 1;
   rx_state_e state_q, state_d;
   logic      arm_q, arm_d, push, pop, full;
   assign full      = level == LW'(DEPTH);
   assign gnt       = state_q == RX_GRANT;
   assign out_valid = level != '0;
   assign pop       = out_valid && out_ready;
   // grant an armed, enabled request when the registered level shows room; release once req drops
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      arm_d   = arm_q || !req;
      if (state_q == RX_IDLE) begin
         push    = req && enable && arm_q && !full;
         state_d = push ? RX_GRANT : RX_IDLE;
      end else if (!req) state_d = RX_IDLE;
   end
   // handshake state; reset disarms grants until req has been seen low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         arm_q   <= arm_d;
      end
   end
   bus_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (data),
      .pop       (pop),
      .head_data (out_data),
      .level     (level)
   );
`ifdef BUS_SLAVE_RX_STATS_EN
   logic [STAT_W-1:0] xfer_q, stall_q;
   assign xfer_count  = xfer_q;
   assign stall_count = stall_q;
   // transfer count wraps; stall count saturates on full-blocked idle requests
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_q  <= '0;
         stall_q <= '0;
      end else begin
         if (push) xfer_q <= xfer_q + 1'b1;
         if (state_q == RX_IDLE && req && enable && full && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_bus_slave_rx.sv
// tb_bus_slave_rx: directed and randomized checks of bus_slave_rx against a queue-based model (BUS_SLAVE_RX_STATS_EN optional)
module tb_bus_slave_rx;
   localparam int DEPTH = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [7:0] data = '0;
   logic       enable = 1'b0;
   logic       out_ready = 1'b0;
   logic       gnt, out_valid;
   logic [7:0] out_data;
   logic [2:0] level;
`ifdef BUS_SLAVE_RX_STATS_EN
   logic [15:0] xfer_count, stall_count;
`endif
   int n_cmp = 0;
   int n_err = 0;

   bus_slave_rx #(.DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .enable    (enable),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level)
`ifdef BUS_SLAVE_RX_STATS_EN
      ,
      .xfer_count  (xfer_count),
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a byte queue, a "transfer in progress" flag and an "armed" flag.
   bit [7:0] mq[$];
   bit       m_busy, m_arm, m_ready;
   int       m_xfer, m_stall;

   always @(negedge clk) begin
      bit take;
      if (m_ready) begin
         chk("m_gnt", gnt, m_busy);
         chk("m_valid", out_valid, mq.size() != 0);
         chk("m_level", level, mq.size());
         if (mq.size() != 0) chk("m_data", out_data, mq[0]);
`ifdef BUS_SLAVE_RX_STATS_EN
         chk("m_xfer", xfer_count, m_xfer);
         chk("m_stall", stall_count, m_stall);
`endif
      end
      if (rst) begin
         mq.delete();
         m_busy  = 0;
         m_arm   = 0;
         m_xfer  = 0;
         m_stall = 0;
         m_ready = 1;
      end else begin
         take = !m_busy && m_arm && req && enable && mq.size() < DEPTH;
         if (!m_busy && req && enable && mq.size() == DEPTH && m_stall != 16'hFFFF) m_stall++;
         if (out_ready && mq.size() != 0) void'(mq.pop_front());
         if (take) begin
            mq.push_back(data);
            m_busy = 1;
            m_xfer = (m_xfer + 1) % 65536;
         end else if (m_busy && !req) m_busy = 0;
         if (!req) m_arm = 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [7:0] b);
      bit got = 0;
      req  = 1'b1;
      data = b;
      for (int i = 0; i < 20 && !got; i++) begin
         step(1);
         got = gnt;
      end
      if (!got) chk("grant_timeout", 0, 1);
      req = 1'b0;
      step(1);
   endtask

   task automatic drain(input logic [7:0] exp);
      chk("drain_data", out_data, exp);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      step(2);
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_level", level, 0);
      rst = 1'b0;
      step(1);
      // single transfer
      enable = 1'b1;
      req    = 1'b1;
      data   = 8'hA5;
      step(1);
      chk("single_gnt", gnt, 1);
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 8'hA5);
      req = 1'b0;
      step(1);
      chk("single_gnt_drop", gnt, 0);
      chk("single_level", level, 1);
      drain(8'hA5);
      // fill to full, 5th request blocked until a pop
      for (int i = 1; i <= 4; i++) xfer(8'(i));
      chk("full_level", level, 4);
      req  = 1'b1;
      data = 8'h05;
      step(3);
      chk("full_gnt", gnt, 0);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk("full_pop_data", out_data, 8'h02);
      chk("full_pop_gnt", gnt, 0);
      step(1);
      chk("full_late_gnt", gnt, 1);
      chk("full_relevel", level, 4);
      req = 1'b0;
      step(1);
      for (int i = 2; i <= 5; i++) drain(8'(i));
      chk("drained", level, 0);
      // enable gating
      enable = 1'b0;
      req    = 1'b1;
      data   = 8'h77;
      step(5);
      chk("en_block", gnt, 0);
      enable = 1'b1;
      step(1);
      chk("en_gnt", gnt, 1);
      req = 1'b0;
      step(1);
      drain(8'h77);
      // simultaneous push/pop and wrap ordering
      xfer(8'h10);
      xfer(8'h11);
      req       = 1'b1;
      data      = 8'h12;
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      chk("pp_level", level, 2);
      chk("pp_gnt", gnt, 1);
      chk("pp_head", out_data, 8'h11);
      req = 1'b0;
      step(1);
      xfer(8'h13);
      xfer(8'h14);
      for (int i = 8'h11; i <= 8'h14; i++) drain(8'(i));
      // reset mid-handshake
      xfer(8'h20);
      xfer(8'h21);
      req  = 1'b1;
      data = 8'h22;
      step(1);
      chk("mid_level", level, 3);
      rst = 1'b1;
      step(1);
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_level", level, 0);
      rst = 1'b0;
      step(4);
      chk("mid_noarm_gnt", gnt, 0);
      req = 1'b0;
      step(1);
      req = 1'b1;
      step(1);
      chk("rearm_gnt", gnt, 1);
      chk("rearm_data", out_data, 8'h22);
      req = 1'b0;
      step(1);
      drain(8'h22);
`ifdef BUS_SLAVE_RX_STATS_EN
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      for (int i = 0; i < 3; i++) xfer(8'h30 + 8'(i));
      chk("stat_xfer", xfer_count, 3);
      xfer(8'h33);
      req = 1'b1;
      step(4);
      chk("stat_stall", stall_count, 4);
      req = 1'b0;
      step(1);
      for (int i = 0; i < 4; i++) drain(8'h30 + 8'(i));
`endif
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         req       = ($urandom_range(0, 3) != 0) ? ~req : req;
         enable    = ($urandom_range(0, 4) != 0);
         out_ready = ($urandom_range(0, 2) == 0);
         data      = 8'($urandom);
         step(1);
      end
      rst = 1'b0;
      req = 1'b0;
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
